// File: rtl/simon_pkg.sv
// Shared types and defaults for the Simon tone sequencer.
package simon_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        RED    = 2'd1,
        YELLOW = 2'd2,
        BLUE   = 2'd3
    } color_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_TONE  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int unsigned DEFAULT_TONE_CYCLES = 25_000_000;
    localparam int unsigned DEFAULT_GAP_CYCLES  = 12_500_000;

    // Timer width wide enough for the larger phase reload value, never zero.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter with a zero flag, shared by the tone and gap phases.
module seq_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/simon_tone_sequencer.sv
// Replays a Simon colour pattern from a synchronous RAM as timed on/off tone
// strobes, and plays single tap tones; busy/done are registered state decodes.
module simon_tone_sequencer
    import simon_pkg::*;
#(
    parameter int unsigned TONE_CYCLES = DEFAULT_TONE_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEFAULT_GAP_CYCLES,
    parameter int unsigned ADDR_W      = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   seq_len,
    input  logic              abort,
    input  logic              tap_valid,
    input  logic [1:0]        tap_color,
    output logic [ADDR_W-1:0] pat_addr,
    input  logic [1:0]        pat_data,
    output logic              play_audio,
    output logic [1:0]        color,
    output logic              on_off,
    output logic              busy,
    output logic              done
);

    localparam int unsigned TW = timer_width(TONE_CYCLES, GAP_CYCLES);
    localparam int unsigned LW = ADDR_W + 1;
    localparam logic [TW-1:0] TONE_LOAD = TW'(TONE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [LW-1:0]     len_q, len_d;
    logic              tap_q, tap_d;
    logic              play_d, on_off_d, busy_d, done_d;
    logic [1:0]        color_d;
    logic              tmr_load, tmr_dec, tmr_zero_c;
    logic [TW-1:0]     tmr_value;
    logic              last_c;
    logic              abort_c;

    // Widened compare so len = 2^ADDR_W does not wrap.
    assign last_c  = ({1'b0, index_q} == (len_q - LW'(1)));
    assign abort_c = abort && (state != S_IDLE);
    assign pat_addr = index_q;

    seq_timer #(.W(TW)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_value),
        .dec        (tmr_dec),
        .zero_c     (tmr_zero_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            index_q    <= '0;
            len_q      <= '0;
            tap_q      <= 1'b0;
            play_audio <= 1'b0;
            color      <= '0;
            on_off     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            index_q    <= index_d;
            len_q      <= len_d;
            tap_q      <= tap_d;
            play_audio <= play_d;
            color      <= color_d;
            on_off     <= on_off_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (seq_len == '0) ? S_DONE : S_FETCH;
                end else if (tap_valid) begin
                    state_next = S_TONE;
                end
            end
            S_FETCH: state_next = S_LOAD;
            S_LOAD:  state_next = S_TONE;
            S_TONE: begin
                if (tmr_zero_c) state_next = tap_q ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (tmr_zero_c) state_next = last_c ? S_DONE : S_FETCH;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort_c) state_next = S_IDLE;
    end

    always_comb begin
        play_d    = 1'b0;
        on_off_d  = on_off;
        color_d   = color;
        index_d   = index_q;
        len_d     = len_q;
        tap_d     = tap_q;
        busy_d    = (state != S_IDLE);
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        tmr_value = TONE_LOAD;
        case (state)
            S_IDLE: begin
                if (start) begin
                    len_d   = seq_len;
                    index_d = '0;
                    tap_d   = 1'b0;
                end else if (tap_valid) begin
                    color_d  = tap_color;
                    play_d   = 1'b1;
                    on_off_d = 1'b1;
                    tap_d    = 1'b1;
                    tmr_load = 1'b1;
                end
            end
            S_LOAD: begin
                color_d  = pat_data;
                play_d   = 1'b1;
                on_off_d = 1'b1;
                tmr_load = 1'b1;
            end
            S_TONE: begin
                if (tmr_zero_c) begin
                    play_d   = 1'b1;
                    on_off_d = 1'b0;
                    if (tap_q) begin
                        tap_d = 1'b0;
                    end else begin
                        tmr_load  = 1'b1;
                        tmr_value = GAP_LOAD;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_GAP: begin
                if (tmr_zero_c) begin
                    if (!last_c) index_d = index_q + ADDR_W'(1);
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
        // Abort silences a sounding tone and drops everything else in flight.
        if (abort_c) begin
            tap_d    = 1'b0;
            done_d   = 1'b0;
            tmr_load = 1'b0;
            tmr_dec  = 1'b0;
            index_d  = index_q;
            color_d  = color;
            play_d   = (state == S_TONE);
            on_off_d = (state == S_TONE) ? 1'b0 : on_off;
        end
    end

endmodule

// File: tb/tb_simon_tone_sequencer.sv
// Directed bench for simon_tone_sequencer: strobe/done events are checked
// against a scoreboard of expected (cycle, kind, colour, on_off) entries.
module tb_simon_tone_sequencer;

    localparam int unsigned TONE = 10;
    localparam int unsigned GAP  = 4;
    localparam int unsigned AW   = 5;

    logic          clock;
    logic          reset;
    logic          start;
    logic [AW:0]   seq_len;
    logic          abort;
    logic          tap_valid;
    logic [1:0]    tap_color;
    logic [AW-1:0] pat_addr;
    logic [1:0]    pat_data;
    logic          play_audio;
    logic [1:0]    color;
    logic          on_off;
    logic          busy;
    logic          done;

    simon_tone_sequencer #(
        .TONE_CYCLES (TONE),
        .GAP_CYCLES  (GAP),
        .ADDR_W      (AW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .seq_len    (seq_len),
        .abort      (abort),
        .tap_valid  (tap_valid),
        .tap_color  (tap_color),
        .pat_addr   (pat_addr),
        .pat_data   (pat_data),
        .play_audio (play_audio),
        .color      (color),
        .on_off     (on_off),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [1:0] ram [0:31];
    always @(posedge clock) pat_data <= ram[pat_addr];

    typedef struct {
        int         at;
        logic [1:0] kind;   // 2'b01 strobe, 2'b10 done
        logic [1:0] col;
        logic       onoff;
    } ev_t;

    ev_t sb[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic push(input int at, input logic [1:0] kind, input logic [1:0] col, input logic onoff);
        ev_t e;
        e.at = at; e.kind = kind; e.col = col; e.onoff = onoff;
        sb.push_back(e);
    endtask

    // Expected strobes/done for a sequence started in cycle t.
    task automatic push_seq(input int t, input int n);
        for (int k = 0; k < n; k++) begin
            push(t + 3 + 16 * k, 2'b01, ram[k], 1'b1);
            push(t + 13 + 16 * k, 2'b01, ram[k], 1'b0);
        end
        push(t + 16 * n + 2, 2'b10, 2'b00, 1'b0);
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    always @(negedge clock) begin
        if (!reset && (play_audio || done)) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                ev_t e;
                e = sb.pop_front();
                check("event_cycle", 32'(cyc), 32'(e.at));
                check("event_kind", 32'({done, play_audio}), 32'(e.kind));
                if (e.kind == 2'b01) begin
                    check("strobe_color", 32'(color), 32'(e.col));
                    check("strobe_on_off", 32'(on_off), 32'(e.onoff));
                end
            end
        end
    end

    int t0;

    initial begin
        reset = 1'b1; start = 1'b0; seq_len = '0; abort = 1'b0;
        tap_valid = 1'b0; tap_color = 2'd0;
        for (int i = 0; i < 32; i++) ram[i] = 2'd0;
        ram[0] = 2'd2; ram[1] = 2'd0; ram[2] = 2'd3;

        goto(3);
        check("rst_play", 32'(play_audio), 32'd0);
        check("rst_color", 32'(color), 32'd0);
        check("rst_on_off", 32'(on_off), 32'd0);
        check("rst_pat_addr", 32'(pat_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;

        // Three-entry replay, with ignored start/tap while busy.
        goto(6);
        t0 = cyc; start = 1'b1; seq_len = 6'd3; push_seq(t0, 3);
        goto(t0 + 1); start = 1'b0;
        check("seq_addr0", 32'(pat_addr), 32'd0);
        goto(t0 + 3);
        check("seq_busy_first_on", 32'(busy), 32'd1);
        goto(t0 + 17);
        check("seq_addr1", 32'(pat_addr), 32'd1);
        goto(t0 + 20);
        start = 1'b1; seq_len = 6'd0; tap_valid = 1'b1; tap_color = 2'd3;
        goto(t0 + 21); start = 1'b0; tap_valid = 1'b0;
        goto(t0 + 33);
        check("seq_addr2", 32'(pat_addr), 32'd2);
        goto(t0 + 50);
        check("seq_busy_at_done", 32'(busy), 32'd1);
        goto(t0 + 51);
        check("seq_busy_after", 32'(busy), 32'd0);
        goto(t0 + 53);
        check("seq_sb_empty", 32'(sb.size()), 32'd0);

        // Zero-length sequence: done only, no strobes.
        t0 = cyc; start = 1'b1; seq_len = 6'd0; push(t0 + 2, 2'b10, 2'b00, 1'b0);
        goto(t0 + 1); start = 1'b0;
        goto(t0 + 2);
        check("zero_busy", 32'(busy), 32'd1);
        goto(t0 + 3);
        check("zero_busy_after", 32'(busy), 32'd0);
        goto(t0 + 5);
        check("zero_sb_empty", 32'(sb.size()), 32'd0);

        // Tap tone.
        t0 = cyc; tap_valid = 1'b1; tap_color = 2'd1;
        push(t0 + 1, 2'b01, 2'd1, 1'b1);
        push(t0 + 11, 2'b01, 2'd1, 1'b0);
        goto(t0 + 1); tap_valid = 1'b0;
        goto(t0 + 13);
        check("tap_busy_after", 32'(busy), 32'd0);
        check("tap_sb_empty", 32'(sb.size()), 32'd0);

        // Abort during the first tone, then a fresh one-entry start.
        goto(t0 + 15);
        t0 = cyc; start = 1'b1; seq_len = 6'd3;
        push(t0 + 3, 2'b01, 2'd2, 1'b1);
        push(t0 + 9, 2'b01, 2'd2, 1'b0);
        goto(t0 + 1); start = 1'b0;
        goto(t0 + 8); abort = 1'b1;
        goto(t0 + 9); abort = 1'b0;
        check("abort_busy_hold", 32'(busy), 32'd1);
        goto(t0 + 10);
        check("abort_busy_low", 32'(busy), 32'd0);
        goto(t0 + 12);
        t0 = cyc; start = 1'b1; seq_len = 6'd1; push_seq(t0, 1);
        goto(t0 + 1); start = 1'b0;
        goto(t0 + 21);
        check("restart_sb_empty", 32'(sb.size()), 32'd0);

        // Reset in the middle of a gap.
        t0 = cyc; start = 1'b1; seq_len = 6'd3;
        push(t0 + 3, 2'b01, 2'd2, 1'b1);
        push(t0 + 13, 2'b01, 2'd2, 1'b0);
        goto(t0 + 1); start = 1'b0;
        goto(t0 + 6); start = 1'b1; tap_valid = 1'b1; tap_color = 2'd1;
        goto(t0 + 7); start = 1'b0; tap_valid = 1'b0;
        goto(t0 + 14); reset = 1'b1;
        goto(t0 + 15); reset = 1'b0;
        check("mid_rst_play", 32'(play_audio), 32'd0);
        check("mid_rst_color", 32'(color), 32'd0);
        check("mid_rst_on_off", 32'(on_off), 32'd0);
        check("mid_rst_pat_addr", 32'(pat_addr), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        goto(t0 + 30);
        check("mid_rst_sb_empty", 32'(sb.size()), 32'd0);

        // Full-length sequence of 32 random colours.
        for (int i = 0; i < 32; i++) ram[i] = 2'($urandom_range(0, 3));
        t0 = cyc; start = 1'b1; seq_len = 6'd32; push_seq(t0, 32);
        goto(t0 + 1); start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            goto(t0 + 1 + 16 * k);
            check("full_pat_addr", 32'(pat_addr), 32'(k));
        end
        goto(t0 + 16 * 32 + 4);
        check("full_busy_after", 32'(busy), 32'd0);
        check("full_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
